uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a small transmit FIFO in front of it.
//   Words written with Tx_WR are buffered and sent as
//   start / data (LSB first) / optional parity / 1 or 2 stop bits.
//   Every bit lasts 16 sample ticks. The sample tick is derived from CLK_HZ
//   and the baud rate chosen by baud_select.
//
// Parameters
//   DATA_BITS  : frame data width (5..9)
//   FIFO_DEPTH : transmit buffer entries (power of 2, >= 2)
//   CLK_HZ     : clk frequency, used to build the baud divisor table
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-low
//   Tx_DATA      : word to enqueue
//   Tx_WR        : one-cycle write strobe
//   Tx_EN        : transmit enable; 0 freezes a frame in progress
//   baud_select  : 300/1200/4800/9600/19200/38400/57600/115200 baud
//   parity_mode  : 00 none, 01 even, 10 odd, 11 none
//   stop2        : 1 = two stop bits
//   TxD          : registered serial line, idles high
//   Tx_BUSY      : frame in progress
//   Tx_FULL      : FIFO full flag
//   Tx_EMPTY     : FIFO empty flag
//   Tx_LEVEL     : FIFO occupancy
//   Tx_OVF       : one-cycle pulse when a write hits a full FIFO
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_HZ     = 50_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        Tx_DATA,
  input  logic                        Tx_WR,
  input  logic                        Tx_EN,
  input  logic [2:0]                  baud_select,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop2,
  output logic                        TxD,
  output logic                        Tx_BUSY,
  output logic                        Tx_FULL,
  output logic                        Tx_EMPTY,
  output logic [$clog2(FIFO_DEPTH):0] Tx_LEVEL,
  output logic                        Tx_OVF
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(DATA_BITS);

  function automatic int baud_of(input int idx);
    case (idx)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded divisor: clk cycles per sample tick (16 ticks per bit).
  function automatic int div_of(input int idx);
    int d;
    d = (CLK_HZ + 8 * baud_of(idx)) / (16 * baud_of(idx));
    return (d < 1) ? 1 : d;
  endfunction

  // The slowest rate has the largest divisor and sets the counter width.
  localparam int DIVW = $clog2(div_of(0) + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  logic [DIVW-1:0] div_table [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_div
    assign div_table[gi] = DIVW'(div_of(gi));
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  state_t               state_reg;
  logic [DIVW-1:0]      div_cnt_reg;
  logic [3:0]           samp_cnt_reg;
  logic [BCW-1:0]       bit_cnt_reg;
  logic [DATA_BITS-1:0] word_reg;
  logic [1:0]           par_mode_reg;
  logic                 stop2_reg;
  logic                 txd_reg;
  logic                 busy_reg;
  logic                 ovf_reg;
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [LW-1:0]        level_reg;

  logic [DIVW-1:0] div_sel;
  logic            running;
  logic            tick;
  logic            bit_end;
  logic            frame_end;
  logic            push;
  logic            pop;
  logic            parity_on;
  logic            parity_bit;
  logic            line_bit;

  assign div_sel    = div_table[baud_select];
  assign running    = (state_reg != IDLE) && Tx_EN;
  assign tick       = running && (div_cnt_reg >= div_sel - DIVW'(1));
  assign bit_end    = tick && (samp_cnt_reg == 4'd15);
  assign frame_end  = bit_end && (((state_reg == STOP1) && !stop2_reg) ||
                                  (state_reg == STOP2));
  assign push       = Tx_WR && !Tx_FULL;
  // Pop either from IDLE or straight out of the last stop bit (no gap).
  assign pop        = !Tx_EMPTY && Tx_EN && ((state_reg == IDLE) || frame_end);
  // 01 and 10 enable parity; bit 1 set means odd.
  assign parity_on  = ^par_mode_reg;
  assign parity_bit = (^word_reg) ^ par_mode_reg[1];

  always_comb begin
    line_bit = 1'b1;
    case (state_reg)
      START:   line_bit = 1'b0;
      DATA:    line_bit = word_reg[bit_cnt_reg];
      PARITY:  line_bit = parity_bit;
      default: line_bit = 1'b1;
    endcase
  end

  // FIFO storage, no reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= Tx_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      samp_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      word_reg     <= '0;
      par_mode_reg <= '0;
      stop2_reg    <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
    end else begin
      ovf_reg <= Tx_WR && Tx_FULL;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase

      // The line follows the state one cycle later; while disabled it holds,
      // so the lag (and every bit length) is preserved across a pause.
      if (Tx_EN || (state_reg == IDLE)) begin
        txd_reg <= line_bit;
      end

      if (tick) begin
        div_cnt_reg  <= '0;
        samp_cnt_reg <= samp_cnt_reg + 4'd1;
      end else if (running) begin
        div_cnt_reg <= div_cnt_reg + DIVW'(1);
      end

      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_reg == BCW'(DATA_BITS - 1)) begin
              state_reg <= parity_on ? PARITY : STOP1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BCW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_reg <= STOP1;
          end
        end
        STOP1: begin
          if (bit_end) begin
            if (stop2_reg) begin
              state_reg <= STOP2;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        STOP2: begin
          if (bit_end) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      // A pop overrides the end-of-frame return to IDLE. The word and the
      // framing options are captured here and held for the whole frame.
      if (pop) begin
        word_reg     <= mem[rd_ptr_reg];
        par_mode_reg <= parity_mode;
        stop2_reg    <= stop2;
        state_reg    <= START;
        busy_reg     <= 1'b1;
        div_cnt_reg  <= '0;
        samp_cnt_reg <= '0;
        bit_cnt_reg  <= '0;
      end
    end
  end

  assign TxD      = txd_reg;
  assign Tx_BUSY  = busy_reg;
  assign Tx_OVF   = ovf_reg;
  assign Tx_LEVEL = level_reg;
  assign Tx_FULL  = (level_reg == LW'(FIFO_DEPTH));
  assign Tx_EMPTY = (level_reg == '0);

endmodule
